// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back, write-allocate data cache.
// A miss stalls the CPU (ram_abort), optionally writes back the dirty victim
// line, fills the line from DRAM one word per dram_rd_val, and the held CPU
// request then replays as a hit.
// Ports:
//   clock, rst            - rising-edge clock, synchronous active-high reset
//   cpu_addr/data_req/wren/byte_en/cpu_wr_data -> cpu_rd_data, hit, ram_abort
//   dram_rd_req/dram_rd_addr <- dram_rd_data/dram_rd_val   (line fill, word addresses)
//   dram_wr_req/dram_wr_addr/dram_wr_data <- dram_wr_val   (line writeback, word addresses)
module dcache_assoc #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned SET_BITS   = 9
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        data_req,
  input  logic        wren,
  input  logic [3:0]  byte_en,
  input  logic [31:0] cpu_wr_data,
  output logic [31:0] cpu_rd_data,
  output logic        hit,
  output logic        ram_abort,
  output logic        dram_rd_req,
  output logic [31:0] dram_rd_addr,
  input  logic [31:0] dram_rd_data,
  input  logic        dram_rd_val,
  output logic        dram_wr_req,
  output logic [31:0] dram_wr_addr,
  output logic [31:0] dram_wr_data,
  input  logic        dram_wr_val
);

  localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
  localparam int unsigned OFF_BITS  = WORD_BITS + 2;
  localparam int unsigned TAG_BITS  = 32 - OFF_BITS - SET_BITS;
  localparam int unsigned SETS      = 1 << SET_BITS;

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);
  localparam logic [WORD_BITS-1:0] WORD_ZERO = '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;

  // Storage arrays; data and tags carry no reset since valid gates their use.
  logic [31:0]         data_mem [2][SETS][LINE_WORDS];
  logic [TAG_BITS-1:0] tag_mem  [2][SETS];
  logic [SETS-1:0]     valid_q  [2];
  logic [SETS-1:0]     dirty_q  [2];
  logic [SETS-1:0]     lru_q;

  // Miss context captured when the miss is accepted.
  logic [TAG_BITS-1:0]  miss_tag;
  logic [SET_BITS-1:0]  miss_set;
  logic                 victim_q;
  logic [WORD_BITS-1:0] wr_cnt;
  logic [WORD_BITS-1:0] rd_cnt;

  logic [WORD_BITS-1:0] cpu_word;
  logic [SET_BITS-1:0]  cpu_set;
  logic [TAG_BITS-1:0]  cpu_tag;
  logic [1:0]           way_hit;
  logic                 hit_any;
  logic                 hit_way;
  logic                 miss_start;
  logic                 victim_c;
  logic                 victim_dirty_c;
  logic                 fill_last;
  logic                 wb_last;
  logic                 unused_addr_bits;

  assign cpu_word         = cpu_addr[OFF_BITS-1:2];
  assign cpu_set          = cpu_addr[OFF_BITS+SET_BITS-1:OFF_BITS];
  assign cpu_tag          = cpu_addr[31:OFF_BITS+SET_BITS];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Tag lookup in both ways.
  always_comb begin
    way_hit[0] = valid_q[0][cpu_set] && (tag_mem[0][cpu_set] == cpu_tag);
    way_hit[1] = valid_q[1][cpu_set] && (tag_mem[1][cpu_set] == cpu_tag);
  end

  assign hit_any    = |way_hit;
  assign hit_way    = way_hit[1];
  assign hit        = data_req && (state == S_IDLE) && hit_any;
  assign miss_start = data_req && (state == S_IDLE) && !hit_any;
  assign ram_abort  = (state != S_IDLE) || (data_req && !hit);

  // Victim choice: fill an empty way first, otherwise evict the LRU way.
  always_comb begin
    victim_c = lru_q[cpu_set];
    if (!valid_q[0][cpu_set]) begin
      victim_c = 1'b0;
    end else if (!valid_q[1][cpu_set]) begin
      victim_c = 1'b1;
    end
    victim_dirty_c = valid_q[victim_c][cpu_set] && dirty_q[victim_c][cpu_set];
  end

  assign wb_last   = (state == S_WB)   && dram_wr_val && (wr_cnt == LAST_WORD);
  assign fill_last = (state == S_FILL) && dram_rd_val && (rd_cnt == LAST_WORD);

  // DRAM side is driven straight from the miss context and current counters.
  assign dram_rd_req  = (state == S_FILL);
  assign dram_rd_addr = {2'b00, miss_tag, miss_set, WORD_ZERO};
  assign dram_wr_req  = (state == S_WB);
  assign dram_wr_addr = {2'b00, tag_mem[victim_q][miss_set], miss_set, WORD_ZERO};
  assign dram_wr_data = data_mem[victim_q][miss_set][wr_cnt];

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (miss_start) begin
          state_nxt = victim_dirty_c ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (wb_last) begin
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Line status, LRU, counters, miss context and read data.
  always_ff @(posedge clock) begin
    if (rst) begin
      valid_q[0]  <= '0;
      valid_q[1]  <= '0;
      dirty_q[0]  <= '0;
      dirty_q[1]  <= '0;
      lru_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      cpu_rd_data <= '0;
      miss_tag    <= '0;
      miss_set    <= '0;
      victim_q    <= 1'b0;
    end else begin
      if (hit) begin
        lru_q[cpu_set] <= !hit_way;
        if (!wren) begin
          cpu_rd_data <= data_mem[hit_way][cpu_set][cpu_word];
        end else if (byte_en != 4'b0000) begin
          dirty_q[hit_way][cpu_set] <= 1'b1;
        end
      end

      if (miss_start) begin
        miss_tag <= cpu_tag;
        miss_set <= cpu_set;
        victim_q <= victim_c;
      end

      if ((state == S_WB) && dram_wr_val) begin
        if (wb_last) begin
          wr_cnt                     <= '0;
          dirty_q[victim_q][miss_set] <= 1'b0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      if ((state == S_FILL) && dram_rd_val) begin
        if (fill_last) begin
          rd_cnt                      <= '0;
          valid_q[victim_q][miss_set] <= 1'b1;
          dirty_q[victim_q][miss_set] <= 1'b0;
          lru_q[miss_set]             <= !victim_q;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Data and tag arrays: byte-masked CPU writes on hit, word writes during fill.
  always_ff @(posedge clock) begin
    if (!rst) begin
      if (hit && wren) begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) begin
            data_mem[hit_way][cpu_set][cpu_word][8*b +: 8] <= cpu_wr_data[8*b +: 8];
          end
        end
      end
      if ((state == S_FILL) && dram_rd_val) begin
        data_mem[victim_q][miss_set][rd_cnt] <= dram_rd_data;
        if (rd_cnt == LAST_WORD) begin
          tag_mem[victim_q][miss_set] <= miss_tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_assoc.sv
// tb_dcache_assoc: randomized scoreboard bench for dcache_assoc.
// Reference: flat architectural memory plus a per-set most-recent-first tag
// list and a dirty map keyed by line; a DRAM responder backs the cache.
module tb_dcache_assoc;

  localparam int unsigned NSETS = 512;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        data_req;
  logic        wren;
  logic [3:0]  byte_en;
  logic [31:0] cpu_wr_data;
  logic [31:0] cpu_rd_data;
  logic        hit;
  logic        ram_abort;
  logic        dram_rd_req;
  logic [31:0] dram_rd_addr;
  logic [31:0] dram_rd_data;
  logic        dram_rd_val;
  logic        dram_wr_req;
  logic [31:0] dram_wr_addr;
  logic [31:0] dram_wr_data;
  logic        dram_wr_val;

  always #5 clock = ~clock;

  dcache_assoc #(.LINE_WORDS(8), .SET_BITS(9)) dut (
    .clock(clock), .rst(rst), .cpu_addr(cpu_addr), .data_req(data_req),
    .wren(wren), .byte_en(byte_en), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .hit(hit), .ram_abort(ram_abort),
    .dram_rd_req(dram_rd_req), .dram_rd_addr(dram_rd_addr),
    .dram_rd_data(dram_rd_data), .dram_rd_val(dram_rd_val),
    .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr),
    .dram_wr_data(dram_wr_data), .dram_wr_val(dram_wr_val)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  bit          hung = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Memories indexed by word address.
  logic [31:0] dram_mem [int unsigned];
  logic [31:0] ref_mem  [int unsigned];

  function automatic logic [31:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] dram_rd(input int unsigned a);
    if (dram_mem.exists(a)) return dram_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Cache-content model: tags per set, most recently used first.
  int unsigned mru [NSETS][$];
  bit          dirty_line [int unsigned];
  logic [31:0] exp_q [$];

  // DRAM responder state.
  bit          rd_always = 1'b1;
  bit          wr_always = 1'b1;
  bit          spur = 1'b0;
  int unsigned rbeat = 0;
  int unsigned wbeat = 0;
  bit          rd_given = 1'b0;
  bit          fill_seen = 1'b0;
  bit          wb_seen = 1'b0;
  logic [31:0] fill_addr_seen = '0;
  logic [31:0] wb_addr_seen = '0;

  // DRAM responder: drives just after each rising edge.
  initial begin
    dram_rd_val  = 1'b0;
    dram_wr_val  = 1'b0;
    dram_rd_data = '0;
    forever begin
      @(posedge clock);
      #1;
      if (rd_given) rbeat++;
      if (!dram_rd_req) rbeat = 0;
      if (dram_rd_req && rbeat == 0 && !fill_seen) begin
        fill_seen      = 1'b1;
        fill_addr_seen = dram_rd_addr;
      end
      rd_given     = dram_rd_req && (rd_always || $urandom_range(0, 2) != 0);
      dram_rd_val  = rd_given || (!dram_rd_req && spur && $urandom_range(0, 1) == 1);
      dram_rd_data = dram_rd_req ? dram_rd(dram_rd_addr + rbeat) : $urandom;

      if (!dram_wr_req) wbeat = 0;
      if (dram_wr_req && wbeat == 0 && !wb_seen) begin
        wb_seen      = 1'b1;
        wb_addr_seen = dram_wr_addr;
      end
      if (dram_wr_req && (wr_always || $urandom_range(0, 2) != 0)) begin
        dram_mem[dram_wr_addr + wbeat] = dram_wr_data;
        wbeat++;
        dram_wr_val = 1'b1;
      end else begin
        dram_wr_val = !dram_wr_req && spur && $urandom_range(0, 1) == 1;
      end
    end
  end

  // Monitor: a read hit presents its data on the following cycle.
  bit rd_pending = 1'b0;
  initial begin
    forever begin
      @(negedge clock);
      if (rd_pending) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: got 0x%08h with no expected value queued", cpu_rd_data);
        end else begin
          chk("rd_data", cpu_rd_data, exp_q.pop_front());
        end
      end
      rd_pending = data_req && hit && !wren && !rst;
    end
  end

  task automatic model_reset();
    for (int s = 0; s < NSETS; s++) mru[s].delete();
    dirty_line.delete();
    exp_q.delete();
    ref_mem = dram_mem;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    rst      = 1'b1;
    data_req = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One CPU access held until accepted; model predicts hit, writeback and fill.
  task automatic cpu_access(input logic [31:0] addr, input bit wr, input logic [3:0] be,
                            input logic [31:0] wdata, output bit first_hit,
                            output int abort_cycles);
    int unsigned line, set, tag, widx, ev_line;
    int          pos;
    bit          exp_hit, exp_wb;
    logic [31:0] w;
    line = addr >> 5;
    set  = line % NSETS;
    tag  = line / NSETS;
    widx = addr >> 2;
    pos  = -1;
    exp_wb  = 1'b0;
    ev_line = 0;
    for (int i = 0; i < mru[set].size(); i++) if (mru[set][i] == tag) pos = i;
    exp_hit = (pos >= 0);
    if (exp_hit) begin
      mru[set].delete(pos);
    end else if (mru[set].size() == 2) begin
      ev_line = mru[set].pop_back() * NSETS + set;
      if (dirty_line.exists(ev_line)) begin
        exp_wb = dirty_line[ev_line];
        dirty_line.delete(ev_line);
      end
    end
    mru[set].push_front(tag);
    if (!exp_hit) dirty_line[line] = 1'b0;

    @(posedge clock);
    #1;
    fill_seen   = 1'b0;
    wb_seen     = 1'b0;
    data_req    = 1'b1;
    cpu_addr    = addr;
    wren        = wr;
    byte_en     = be;
    cpu_wr_data = wdata;
    @(negedge clock);
    first_hit = hit;
    chk("hit_first", 32'(hit), 32'(exp_hit));
    abort_cycles = 0;
    while (ram_abort && abort_cycles < 400) begin
      @(negedge clock);
      abort_cycles++;
    end
    if (ram_abort) begin
      checks++;
      errors++;
      hung = 1'b1;
      $display("FAIL stall_timeout: ram_abort still 1 after %0d cycles, expected 0", abort_cycles);
    end else begin
      chk("hit_accept", 32'(hit), 32'd1);
      if (!exp_hit) begin
        chk("fill_seen", 32'(fill_seen), 32'd1);
        chk("fill_addr", fill_addr_seen, 32'(line * 8));
        chk("wb_seen", 32'(wb_seen), 32'(exp_wb));
        if (exp_wb && wb_seen) chk("wb_addr", wb_addr_seen, 32'(ev_line * 8));
      end
      if (!wr) begin
        exp_q.push_back(ref_rd(widx));
      end else begin
        w = ref_rd(widx);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        ref_mem[widx] = w;
        if (be != 4'b0000) dirty_line[line] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    data_req = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          h;
    int          ac;
    int          waitc;
    logic [31:0] a;
    logic [17:0] tg;
    rst = 1'b1;
    data_req = 1'b0;
    cpu_addr = '0;
    wren = 1'b0;
    byte_en = '0;
    cpu_wr_data = '0;
    repeat (2) @(posedge clock);
    do_reset();

    // Reset state.
    @(negedge clock);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_abort", 32'(ram_abort), 32'd0);
    chk("rst_rd_req", 32'(dram_rd_req), 32'd0);
    chk("rst_wr_req", 32'(dram_wr_req), 32'd0);
    chk("rst_rd_data", cpu_rd_data, 32'd0);

    // Cold read with a val every cycle: 9 stall cycles, then a hit.
    cpu_access(32'h0000_1000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("cold_abort_cycles", 32'(ac), 32'd9);
    cpu_access(32'h0000_1000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("cold_reread_hit", 32'(h), 32'd1);

    // LRU eviction of a clean line.
    do_reset();
    cpu_access(32'h0000_0000, 1'b0, 4'h0, 32'h0, h, ac);
    cpu_access(32'h0000_4000, 1'b0, 4'h0, 32'h0, h, ac);
    cpu_access(32'h0000_0000, 1'b0, 4'h0, 32'h0, h, ac);
    cpu_access(32'h0000_8000, 1'b0, 4'h0, 32'h0, h, ac);
    cpu_access(32'h0000_0000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("lru_keep_hit", 32'(h), 32'd1);
    cpu_access(32'h0000_4000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("lru_evicted_miss", 32'(h), 32'd0);

    // Dirty victim writeback.
    do_reset();
    cpu_access(32'h0000_0004, 1'b1, 4'hF, 32'hDEAD_BEEF, h, ac);
    cpu_access(32'h0000_4000, 1'b1, 4'hF, 32'h1234_5678, h, ac);
    cpu_access(32'h0000_8000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("wb_word1", dram_rd(32'd1), 32'hDEAD_BEEF);

    // Byte-enable merge.
    cpu_access(32'h0000_0104, 1'b1, 4'hF, 32'hAABB_CCDD, h, ac);
    cpu_access(32'h0000_0104, 1'b1, 4'h3, 32'h1122_3344, h, ac);
    cpu_access(32'h0000_0104, 1'b0, 4'h0, 32'h0, h, ac);
    chk("be_merge", cpu_rd_data, 32'hAABB_3344);

    // Reset in the middle of a writeback.
    do_reset();
    cpu_access(32'h0000_0004, 1'b1, 4'hF, 32'hCAFE_F00D, h, ac);
    cpu_access(32'h0000_4000, 1'b1, 4'hF, 32'h0BAD_F00D, h, ac);
    @(posedge clock);
    #1;
    wb_seen  = 1'b0;
    data_req = 1'b1;
    cpu_addr = 32'h0000_8000;
    wren     = 1'b0;
    waitc    = 0;
    @(negedge clock);
    while (wbeat < 3 && waitc < 100) begin
      @(negedge clock);
      waitc++;
    end
    chk("midwb_reached", 32'(wbeat >= 3), 32'd1);
    @(posedge clock);
    #1;
    rst      = 1'b1;
    data_req = 1'b0;
    @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    chk("midwb_wr_req", 32'(dram_wr_req), 32'd0);
    chk("midwb_abort", 32'(ram_abort), 32'd0);
    chk("midwb_rd_req", 32'(dram_rd_req), 32'd0);
    chk("midwb_rd_data", cpu_rd_data, 32'd0);
    model_reset();
    cpu_access(32'h0000_0004, 1'b0, 4'h0, 32'h0, h, ac);
    chk("midwb_line0_miss", 32'(h), 32'd0);
    cpu_access(32'h0000_4000, 1'b0, 4'h0, 32'h0, h, ac);
    chk("midwb_line4000_miss", 32'(h), 32'd0);

    // Randomized traffic with random DRAM latency and spurious vals.
    rd_always = 1'b0;
    wr_always = 1'b0;
    spur      = 1'b1;
    for (int n = 0; n < 400 && !hung; n++) begin
      case ($urandom_range(0, 3))
        0: tg = 18'h0_0000;
        1: tg = 18'h0_0001;
        2: tg = 18'h0_0002;
        default: tg = 18'h3_FFFF;
      endcase
      a = {tg, 9'($urandom_range(0, 2)), 3'($urandom_range(0, 7)), 2'b00};
      cpu_access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, h, ac);
      repeat ($urandom_range(0, 2)) @(posedge clock);
    end
    spur = 1'b0;
    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_assoc.md
DCACHE_ASSOC -- requirements
Module: dcache_assoc

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8: 32-bit words per line, power of 2, ≥2.
REQ-002 SHALL have parameter SET_BITS, default 9: index width, giving 2^SET_BITS sets × 2 ways.
REQ-003 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port cpu_addr, input, 32: byte address; OFF=log2(LINE_WORDS)+2 offset bits, then SET_BITS index, remaining bits tag.
REQ-006 SHALL have ports data_req in 1, wren in 1 (1=write), byte_en in 4, cpu_wr_data in 32, cpu_rd_data out 32.
REQ-007 SHALL have ports hit out 1 and ram_abort out 1 (CPU stall).
REQ-008 SHALL have ports dram_rd_req out 1, dram_rd_addr out 32, dram_rd_data in 32, dram_rd_val in 1.
REQ-009 SHALL have ports dram_wr_req out 1, dram_wr_addr out 32, dram_wr_data out 32, dram_wr_val in 1.

Function
REQ-010 SHALL be 2-way set-associative, write-back, write-allocate, with per-line valid, dirty and tag, and one LRU bit per set.
REQ-011 SHALL drive hit combinationally = data_req & state==IDLE & (valid & tag match in either way).
REQ-012 SHALL, on a read hit, load cpu_rd_data with the addressed word at the same edge (1-cycle latency); otherwise hold cpu_rd_data.
REQ-013 SHALL, on a write hit, write only the bytes selected by byte_en and set dirty when byte_en≠0.
REQ-014 SHALL, on any hit, set LRU[set] to the way not hit.
REQ-015 SHALL use FSM states IDLE, WB, FILL.
REQ-016 SHALL, on data_req & ~hit in IDLE, latch cpu_addr and choose the victim: invalid way0, else invalid way1, else way LRU[set].
REQ-017 SHALL go IDLE→WB if the victim is valid and dirty, else IDLE→FILL.
REQ-018 SHALL, in WB, hold dram_wr_req=1, dram_wr_addr={victim tag, index, 0 offset}>>2 (word address), and dram_wr_data=victim word wr_cnt (combinational).
REQ-019 SHALL advance wr_cnt on each dram_wr_val; after LINE_WORDS vals, clear victim dirty, zero wr_cnt and go WB→FILL.
REQ-020 SHALL, in FILL, hold dram_rd_req=1, dram_rd_addr=latched line byte address>>2, and write dram_rd_data into victim word rd_cnt on each dram_rd_val.
REQ-021 SHALL, on the LINE_WORDS-th dram_rd_val, set victim valid=1, tag=latched tag, dirty=0, LRU[set]=other way, zero rd_cnt and go FILL→IDLE.
REQ-022 SHALL drive ram_abort = (state≠IDLE) | (data_req & ~hit); the CPU holds its request stable while ram_abort=1 and the request replays as a hit after the fill.
REQ-023 SHALL ignore dram_wr_val outside WB, dram_rd_val outside FILL, and CPU requests outside IDLE.
REQ-024 SHALL complete an in-flight miss even if data_req drops mid-miss.
REQ-025 SHALL deassert dram_rd_req/dram_wr_req in the cycle after the final val.

Reset
REQ-026 SHALL, on rst (at any time, including mid-WB/FILL), go to IDLE, clear all valid, dirty and LRU bits, zero counters and cpu_rd_data; hit, ram_abort, dram_rd_req and dram_wr_req are 0 after that edge.
REQ-027 SHALL drop an interrupted writeback or fill without partial line install.

Verification (LINE_WORDS=8, SET_BITS=9)
REQ-028 Cold read 0x0000_1000, dram_rd_val every cycle → ram_abort=1 for 9 cycles, dram_rd_addr=0x400; on the next cycle hit=1, and cpu_rd_data = first fill word one cycle later.
REQ-029 Read 0x0000_0000, then 0x0000_4000, then re-read 0x0000_0000 (hit), then read 0x0000_8000 → line 0x4000 is evicted (no WB); a re-read of 0x0000_0000 hits.
REQ-030 Write 0xDEADBEEF to 0x0000_0004 (be=F), write to 0x0000_4000, then read 0x0000_8000 → WB with dram_wr_addr=0x0, 8 words, word1=0xDEADBEEF, then FILL with dram_rd_addr=0x2000.
REQ-031 Word holding 0xAABBCCDD, write 0x11223344 with be=0011 → subsequent read returns 0xAABB3344.
REQ-032 rst asserted in WB after 3 dram_wr_val → next cycle dram_wr_req=0, ram_abort=0; all prior addresses miss.
REQ-033 Spurious dram_rd_val in IDLE/WB → no array or counter change.
